// File: rtl/uart_pkg.sv
// Frame layout constants and the receive FSM state type shared by the RX frame path.
package uart_pkg;

   localparam int FRAME_W  = 11;
   localparam int START    = 0;
   localparam int DATA_LSB = 1;
   localparam int DATA_MSB = 8;
   localparam int PARITY   = 9;
   localparam int STOP     = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO with occupancy count; push and pop may coincide even when full.
module rx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [7:0]                 wr_data,
   input  logic                       pop,
   output logic [7:0]                 rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem_q[rptr_q];

   always_comb begin
      do_pop  = pop & ~empty;
      // A full FIFO still accepts a write when the head is leaving in the same cycle.
      do_push = push & (~full | do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset) mem_q[wptr_q] <= wr_data;
   end

endmodule

// File: rtl/rx_frame_fifo.sv
// Captures completed UART frames on the rising edge of the registered receive flag,
// checks start/stop/parity, and queues good data bytes into a FWFT FIFO with sticky errors.
module rx_frame_fifo
   import uart_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0,
   parameter int DEPTH      = 8
) (
   input  logic                       baud_clk,
   input  logic                       reset,
   input  logic                       recieved_flag,
   input  logic [FRAME_W-1:0]         data_parll,
   input  logic                       rd_ready,
   input  logic                       err_clr,
   output logic [7:0]                 rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       parity_err,
   output logic                       frame_err,
   output logic                       overrun_err
);

   rx_state_e          state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               rf_q, rf_prev_q;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               oerr_q, oerr_d;
   logic               new_frame, push, pop_fire, fifo_empty, fifo_full;
   logic               bad_frame, bad_parity;

   assign new_frame = rf_q & ~rf_prev_q;
   assign pop_fire  = rd_ready & ~fifo_empty;
   assign rd_valid  = ~fifo_empty;

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      push       = 1'b0;
      bad_frame  = (frame_q[START] != 1'b0) || (frame_q[STOP] != 1'b1);
      bad_parity = (^frame_q[PARITY:DATA_LSB]) != PARITY_ODD;
      perr_d     = err_clr ? 1'b0 : perr_q;
      ferr_d     = err_clr ? 1'b0 : ferr_q;
      oerr_d     = err_clr ? 1'b0 : oerr_q;
      case (state_q)
         IDLE: begin
            if (new_frame) begin
               frame_d = data_parll;
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (bad_frame)  ferr_d = 1'b1;
            if (bad_parity) perr_d = 1'b1;
            if (!bad_frame && !bad_parity) begin
               if (!fifo_full || pop_fire) push   = 1'b1;
               else                         oerr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The flag history resets high so a level already asserted at release is not a new frame.
   always_ff @(posedge baud_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         rf_q      <= 1'b1;
         rf_prev_q <= 1'b1;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         oerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         rf_q      <= recieved_flag;
         rf_prev_q <= rf_q;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         oerr_q    <= oerr_d;
      end
   end

   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;

   rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (baud_clk),
      .reset   (reset),
      .push    (push),
      .wr_data (frame_q[DATA_MSB:DATA_LSB]),
      .pop     (rd_ready),
      .rd_data (rd_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

endmodule
